// File: rtl/fir_output_packer_pkg.sv
// Shared constants for the FIR output packer: default widths, FIFO geometry
// and the saturation limits of the packed output sample.
package fir_output_packer_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 7;
  localparam int DEF_DEPTH = 8;

  localparam int PTR_W = $clog2(DEF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam int SAT_MAX = (1 << (DEF_OUT_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DEF_OUT_W - 1));

  // Occupancy counters need one extra bit so that "full" is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fir_output_packer_sync_fifo.sv
// First-word fall-through synchronous FIFO; the head entry is always visible
// on o_data. Pushes are accepted when not full, or when a pop frees a slot.
module sync_fifo
  import fir_output_packer_pkg::*;
#(
  parameter int WIDTH = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic [WIDTH-1:0]            i_data,
  output logic [WIDTH-1:0]            o_data,
  output logic [cnt_width(DEPTH)-1:0] o_count,
  output logic                        o_empty,
  output logic                        o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == {CW{1'b0}});
  assign o_full  = (r_count == FULL_CNT);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/fir_output_packer.sv
// Rounds and saturates FIR results to the output width, stages them for one
// cycle, and buffers them in an FWFT FIFO with sticky clip/drop flags.
module fir_output_packer
  import fir_output_packer_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic signed [IN_W-1:0]      in_data,
  input  logic                        in_valid,
  output logic signed [OUT_W-1:0]     out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        sat_flag,
  output logic                        overflow,
  input  logic                        clr_flags
);

  localparam logic signed [IN_W:0] RND    = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] SAT_LO = ~SAT_HI;

  logic signed [IN_W:0]  w_ext;
  logic signed [IN_W:0]  w_sum;
  logic signed [IN_W:0]  w_shr;
  logic [OUT_W-1:0]      w_sat;
  logic                  w_clip;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_drop;
  logic [OUT_W-1:0]      w_fifo_data;

  logic                  r_stage_valid;
  logic [OUT_W-1:0]      r_stage_data;
  logic                  r_sat_flag;
  logic                  r_overflow;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  always_comb begin
    w_ext  = {in_data[IN_W-1], in_data};
    w_sum  = w_ext + RND;
    w_shr  = w_sum >>> SHIFT;
    w_sat  = w_shr[OUT_W-1:0];
    w_clip = 1'b0;
    if (w_shr > SAT_HI) begin
      w_sat  = {1'b0, {(OUT_W-1){1'b1}}};
      w_clip = 1'b1;
    end else if (w_shr < SAT_LO) begin
      w_sat  = {1'b1, {(OUT_W-1){1'b0}}};
      w_clip = 1'b1;
    end else begin
      w_sat  = w_shr[OUT_W-1:0];
      w_clip = 1'b0;
    end
  end

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign w_drop    = r_stage_valid & w_full & ~w_pop;
  assign out_data  = w_fifo_data;
  assign sat_flag  = r_sat_flag;
  assign overflow  = r_overflow;

  // Stage register and sticky flags; a new event outranks a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stage_valid <= 1'b0;
      r_stage_data  <= {OUT_W{1'b0}};
      r_sat_flag    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_stage_valid <= in_valid;
      if (in_valid) r_stage_data <= w_sat;
      r_sat_flag    <= (in_valid & w_clip) | (r_sat_flag & ~clr_flags);
      r_overflow    <= w_drop | (r_overflow & ~clr_flags);
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (r_stage_valid),
    .i_pop   (out_ready),
    .i_data  (r_stage_data),
    .o_data  (w_fifo_data),
    .o_count (count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

endmodule

// File: tb/tb_fir_output_packer.sv
// Directed bench for fir_output_packer: expected samples are queued at issue
// time and a negedge monitor compares every accepted output in order.
module tb_fir_output_packer;

  logic               CLK = 1'b0;
  logic               RST;
  logic signed [31:0] in_data;
  logic               in_valid;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         count;
  logic               sat_flag;
  logic               overflow;
  logic               clr_flags;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  fir_output_packer dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .sat_flag  (sat_flag),
    .overflow  (overflow),
    .clr_flags (clr_flags)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic signed [31:0] d, input bit push_exp, input int e);
    in_valid = 1'b1;
    in_data  = d;
    if (push_exp) exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    check(nm, (n < 100) ? 1 : 0, 1);
  endtask

  // Scoreboard monitor: every accepted output must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d expected none", out_data);
      end else begin
        check("out_data", int'(out_data), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_data = 32'sd0; out_ready = 1'b0; clr_flags = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    check("reset_count", int'(count), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_sat", int'(sat_flag), 0);
    check("reset_ovf", int'(overflow), 0);

    // Basic latency: strobe in cycle t, output visible in t+2.
    out_ready = 1'b1;
    send(32'sd12800, 1'b1, 100);
    check("lat_t1_valid", int'(out_valid), 0);
    tick();
    check("lat_t2_valid", int'(out_valid), 1);
    check("lat_t2_data", int'(out_data), 100);
    drain("drain_a");

    // Round-half-up on both signs.
    send(32'sd192, 1'b1, 2);
    send(-32'sd192, 1'b1, -1);
    drain("drain_b");
    check("no_sat_b", int'(sat_flag), 0);

    // Saturation and sticky flag behaviour.
    send(32'sh7FFFFFFF, 1'b1, 32767);
    check("sat_set", int'(sat_flag), 1);
    send(32'sh80000000, 1'b1, -32768);
    drain("drain_c");
    check("sat_sticky", int'(sat_flag), 1);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    check("sat_cleared", int'(sat_flag), 0);
    clr_flags = 1'b1;
    send(32'sh7FFFFFFF, 1'b1, 32767);
    clr_flags = 1'b0;
    check("sat_event_wins", int'(sat_flag), 1);
    drain("drain_c2");
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;

    // Fill past capacity with the consumer stalled.
    out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) send(k * 128, (k <= 8), k);
    tick();
    check("full_count", int'(count), 8);
    check("full_ovf", int'(overflow), 1);
    drain("drain_d");
    check("drained_count", int'(count), 0);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    check("ovf_cleared", int'(overflow), 0);

    // Sustained push+pop at full occupancy across several pointer wraps.
    for (int i = 0; i < 29; i++) begin
      out_ready = (i >= 9);
      send((100 + i) * 128, 1'b1, 100 + i);
      if (i >= 8) begin
        check("steady_count", int'(count), 8);
        check("steady_ovf", int'(overflow), 0);
      end
    end
    drain("drain_e");

    // Reset with data in flight, taking priority over concurrent inputs.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send((k == 0) ? 32'sh7FFFFFFF : 32'sd640, 1'b0, 0);
    check("pre_rst_count", int'(count), 5);
    check("pre_rst_sat", int'(sat_flag), 1);
    RST = 1'b1; in_valid = 1'b1; in_data = 32'sh7FFFFFFF; out_ready = 1'b1; clr_flags = 1'b0;
    exp_q.delete();
    tick();
    RST = 1'b0; in_valid = 1'b0;
    check("rst_count", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sat", int'(sat_flag), 0);
    check("rst_ovf", int'(overflow), 0);
    repeat (5) begin
      tick();
      check("no_stale", int'(out_valid), 0);
    end
    send(32'sd640, 1'b1, 5);
    drain("drain_f");
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
